lcd_reset_sequencer: RTL

Parametrised reset-pulse sequencer for HX8352-class LCD panels: holds the panel in reset during FPGA reset, then emits a programmable train of reset pulses, a post-release settle wait, and a completion flag/strobe. It sits between the system clock/reset and the LCD init command FSM, which waits on `lcd_rst_done` before sending commands. All durations are in prescaler ticks, so one build covers simulation (tiny values) and silicon (ms-scale values) by parameter override only.

---
 rtl/lcd_pkg.sv | 12 +
 rtl/lcd_tick_prescaler.sv | 17 +
 rtl/lcd_reset_sequencer.sv | 75 +++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding and reset-pin polarity helper for the LCD reset sequencer.
package lcd_pkg;
  typedef enum logic [1:0] {
    S_ASSERT = 2'd0,
    S_GAP    = 2'd1,
    S_POST   = 2'd2,
    S_DONE   = 2'd3
  } state_t;
  function automatic logic pin_level(input bit active_low, input bit asserted);
    return asserted ^ active_low;
  endfunction
endpackage

// File: rtl/lcd_tick_prescaler.sv
// lcd_tick_prescaler: emits a one-cycle tick every DIV clocks; clr restarts the count.
module lcd_tick_prescaler #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/lcd_reset_sequencer.sv
// lcd_reset_sequencer: LCD panel reset pulse train, settle wait and done flag/strobe.
module lcd_reset_sequencer
  import lcd_pkg::*;
#(
  parameter int TICK_DIV       = 50,
  parameter int ASSERT_TICKS   = 10_000,
  parameter int GAP_TICKS      = 10_000,
  parameter int POST_TICKS     = 120_000,
  parameter int NUM_PULSES     = 1,
  parameter int CNT_W          = 24,
  parameter bit RST_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic lcd_rst,
  output logic lcd_rst_done,
  output logic lcd_rst_done_stb
);
  localparam logic PIN_ON  = pin_level(RST_ACTIVE_LOW, 1'b1);
  localparam logic PIN_OFF = pin_level(RST_ACTIVE_LOW, 1'b0);
  localparam int MAX_AG = ASSERT_TICKS > GAP_TICKS ? ASSERT_TICKS : GAP_TICKS;
  localparam int MAX_T  = MAX_AG > POST_TICKS ? MAX_AG : POST_TICKS;
  if (TICK_DIV < 1 || ASSERT_TICKS < 1 || GAP_TICKS < 1 || POST_TICKS < 1 ||
      NUM_PULSES < 1 || NUM_PULSES > 15 || CNT_W < 1 ||
      (longint'(MAX_T) - 1) >= (longint'(1) << CNT_W)) begin : g_param_err
    $error("lcd_reset_sequencer: illegal parameter set");
  end
  state_t           state, nxt;
  logic [3:0]       pulse_cnt;
  logic [CNT_W-1:0] dur_cnt, dur_last;
  logic             tick, expire;
  lcd_tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (restart || expire),
    .tick (tick)
  );
  always_comb begin
    dur_last = state == S_ASSERT ? CNT_W'(ASSERT_TICKS - 1) :
               state == S_GAP    ? CNT_W'(GAP_TICKS - 1)    : CNT_W'(POST_TICKS - 1);
    expire   = tick && state != S_DONE && dur_cnt == dur_last;
    nxt      = state == S_ASSERT ? (pulse_cnt < 4'(NUM_PULSES - 1) ? S_GAP : S_POST) :
               state == S_GAP    ? S_ASSERT : S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_ASSERT;
      pulse_cnt        <= '0;
      dur_cnt          <= '0;
      lcd_rst          <= PIN_ON;
      lcd_rst_done     <= 1'b0;
      lcd_rst_done_stb <= 1'b0;
    end else if (restart) begin
      state            <= S_ASSERT;
      pulse_cnt        <= '0;
      dur_cnt          <= '0;
      lcd_rst          <= PIN_ON;
      lcd_rst_done     <= 1'b0;
      lcd_rst_done_stb <= 1'b0;
    end else begin
      lcd_rst_done_stb <= 1'b0;
      if (expire) begin
        state            <= nxt;
        dur_cnt          <= '0;
        pulse_cnt        <= state == S_GAP ? pulse_cnt + 4'd1 : pulse_cnt;
        lcd_rst          <= nxt == S_ASSERT ? PIN_ON : PIN_OFF;
        lcd_rst_done     <= nxt == S_DONE;
        lcd_rst_done_stb <= nxt == S_DONE;
      end else if (tick && state != S_DONE) begin
        dur_cnt <= dur_cnt + 1'b1;
      end
    end
  end
endmodule
